// File: rtl/parking_pkg.sv
// Shared sizing constants, slot index type and controller state encoding
// for the parking slot manager.
package parking_pkg;

   localparam int NUM_SLOTS = 16;
   localparam int VNO_W     = 32;
   localparam int SLOT_W    = 4;
   localparam int CNT_W     = 5;

   typedef logic [SLOT_W-1:0] slot_idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALLOC  = 2'd1,
      SCAN   = 2'd2,
      REPORT = 2'd3
   } state_e;

endpackage

// File: rtl/free_slot_finder.sv
// Combinational lowest-index free slot picker: priority encoder over the
// inverted occupancy vector, plus a flag when every slot is taken.
module free_slot_finder
   import parking_pkg::*;
#(
   parameter int N = NUM_SLOTS
) (
   input  logic [N-1:0]      occ_i,
   output logic [SLOT_W-1:0] idx_o,
   output logic              none_free_o
);

   logic [N-1:0] free;

   assign free        = ~occ_i;
   assign none_free_o = ~|free;

   // Walk from the top down so the lowest free index is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (free[i]) idx_o = SLOT_W'(i);
      end
   end

endmodule

// File: rtl/parking_slot_manager.sv
// Parking slot manager: assigns the lowest free slot to entering vehicles,
// scans slots one per cycle to release leaving vehicles, and buffers one
// park and one exit request that arrive while an operation is in progress.
module parking_slot_manager
   import parking_pkg::*;
#(
   parameter int NUM_SLOTS = parking_pkg::NUM_SLOTS,
   parameter int VNO_W     = parking_pkg::VNO_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             car_parked,
   input  logic [VNO_W-1:0] vehicle_no,
   input  logic             exit_req,
   input  logic [VNO_W-1:0] exit_vehicle_no,
   output logic             slot_valid,
   output logic [3:0]       slot_id,
   output logic             park_reject,
   output logic             exit_done,
   output logic [3:0]       exit_slot,
   output logic             exit_err,
   output logic [4:0]       occupancy,
   output logic             full,
   output logic             busy,
   output logic             overflow
);

   state_e               state_q, state_d;
   logic [NUM_SLOTS-1:0] occ_q, occ_d;
   logic [VNO_W-1:0]     vno_q [NUM_SLOTS];
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   slot_idx_t            scan_q, scan_d;
   logic [VNO_W-1:0]     cur_vno_q, cur_vno_d;
   logic                 park_pend_q, park_pend_d;
   logic [VNO_W-1:0]     park_vno_q, park_vno_d;
   logic                 exit_pend_q, exit_pend_d;
   logic [VNO_W-1:0]     exit_vno_q, exit_vno_d;
   logic                 ovf_q, ovf_d;
   logic                 slot_valid_q, slot_valid_d;
   logic                 park_reject_q, park_reject_d;
   logic                 exit_done_q, exit_done_d;
   logic                 exit_err_q, exit_err_d;
   slot_idx_t            slot_id_q, slot_id_d;
   slot_idx_t            exit_slot_q, exit_slot_d;

   slot_idx_t            free_idx;
   logic                 none_free;
   logic                 vno_we;
   logic                 park_take, exit_take;

   free_slot_finder #(.N(NUM_SLOTS)) u_finder (
      .occ_i       (occ_q),
      .idx_o       (free_idx),
      .none_free_o (none_free)
   );

   // Next-state logic: request arbitration, pending latches and the FSM.
   always_comb begin
      // NOTE: every _d starts from its held value so no path leaves a latch.
      state_d       = state_q;
      occ_d         = occ_q;
      cnt_d         = cnt_q;
      scan_d        = scan_q;
      cur_vno_d     = cur_vno_q;
      park_pend_d   = park_pend_q;
      park_vno_d    = park_vno_q;
      exit_pend_d   = exit_pend_q;
      exit_vno_d    = exit_vno_q;
      ovf_d         = ovf_q;
      slot_valid_d  = 1'b0;
      park_reject_d = 1'b0;
      exit_done_d   = 1'b0;
      exit_err_d    = 1'b0;
      slot_id_d     = slot_id_q;
      exit_slot_d   = exit_slot_q;
      vno_we        = 1'b0;

      // Park always wins; an exit in the same cycle waits in its latch.
      park_take = (state_q == IDLE) && (park_pend_q || car_parked);
      exit_take = (state_q == IDLE) && !park_take && (exit_pend_q || exit_req);

      // A latch is free if empty or being drained this cycle.
      if (park_take && park_pend_q) park_pend_d = 1'b0;
      if (car_parked && !(park_take && !park_pend_q)) begin
         if (park_pend_q && !park_take) begin
            ovf_d = 1'b1;
         end else begin
            park_pend_d = 1'b1;
            park_vno_d  = vehicle_no;
         end
      end

      if (exit_take && exit_pend_q) exit_pend_d = 1'b0;
      if (exit_req && !(exit_take && !exit_pend_q)) begin
         if (exit_pend_q && !exit_take) begin
            ovf_d = 1'b1;
         end else begin
            exit_pend_d = 1'b1;
            exit_vno_d  = exit_vehicle_no;
         end
      end

      case (state_q)
         IDLE: begin
            if (park_take) begin
               state_d   = ALLOC;
               cur_vno_d = park_pend_q ? park_vno_q : vehicle_no;
            end else if (exit_take) begin
               state_d   = SCAN;
               scan_d    = '0;
               cur_vno_d = exit_pend_q ? exit_vno_q : exit_vehicle_no;
            end
         end
         ALLOC: begin
            state_d = IDLE;
            if (none_free) begin
               park_reject_d = 1'b1;
            end else begin
               occ_d[free_idx] = 1'b1;
               vno_we          = 1'b1;
               slot_valid_d    = 1'b1;
               slot_id_d       = free_idx;
               if (cnt_q != CNT_W'(NUM_SLOTS)) cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SCAN: begin
            if (occ_q[scan_q] && (vno_q[scan_q] == cur_vno_q)) begin
               occ_d[scan_q] = 1'b0;
               exit_done_d   = 1'b1;
               exit_slot_d   = scan_q;
               state_d       = REPORT;
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end else if (scan_q == SLOT_W'(NUM_SLOTS - 1)) begin
               exit_err_d = 1'b1;
               state_d    = IDLE;
            end else begin
               scan_d = scan_q + SLOT_W'(1);
            end
         end
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state, occupancy bits, pending latches and output pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         occ_q         <= '0;
         cnt_q         <= '0;
         scan_q        <= '0;
         cur_vno_q     <= '0;
         park_pend_q   <= 1'b0;
         park_vno_q    <= '0;
         exit_pend_q   <= 1'b0;
         exit_vno_q    <= '0;
         ovf_q         <= 1'b0;
         slot_valid_q  <= 1'b0;
         park_reject_q <= 1'b0;
         exit_done_q   <= 1'b0;
         exit_err_q    <= 1'b0;
         slot_id_q     <= '0;
         exit_slot_q   <= '0;
      end else begin
         state_q       <= state_d;
         occ_q         <= occ_d;
         cnt_q         <= cnt_d;
         scan_q        <= scan_d;
         cur_vno_q     <= cur_vno_d;
         park_pend_q   <= park_pend_d;
         park_vno_q    <= park_vno_d;
         exit_pend_q   <= exit_pend_d;
         exit_vno_q    <= exit_vno_d;
         ovf_q         <= ovf_d;
         slot_valid_q  <= slot_valid_d;
         park_reject_q <= park_reject_d;
         exit_done_q   <= exit_done_d;
         exit_err_q    <= exit_err_d;
         slot_id_q     <= slot_id_d;
         exit_slot_q   <= exit_slot_d;
      end
   end

   // Vehicle numbers stored on allocation.
   // NOTE: no reset here -- a stale number is harmless because its occ bit is clear.
   always_ff @(posedge clk) begin
      if (vno_we) vno_q[free_idx] <= cur_vno_q;
   end

   assign slot_valid  = slot_valid_q;
   assign slot_id     = slot_id_q;
   assign park_reject = park_reject_q;
   assign exit_done   = exit_done_q;
   assign exit_slot   = exit_slot_q;
   assign exit_err    = exit_err_q;
   assign occupancy   = cnt_q;
   assign full        = (cnt_q == CNT_W'(NUM_SLOTS));
   assign busy        = (state_q != IDLE);
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed bench for parking_slot_manager: park/exit latency, full lot,
// slot reuse, unknown exit, request collision with pending/overflow, and
// reset in the middle of a scan.
module tb_parking_slot_manager;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        car_parked = 1'b0;
   logic [31:0] vehicle_no = '0;
   logic        exit_req = 1'b0;
   logic [31:0] exit_vehicle_no = '0;
   logic        slot_valid, park_reject, exit_done, exit_err;
   logic        full, busy, overflow;
   logic [3:0]  slot_id, exit_slot;
   logic [4:0]  occupancy;

   int n_vec  = 0;
   int n_miss = 0;

   parking_slot_manager dut (
      .clk             (clk),
      .reset           (reset),
      .car_parked      (car_parked),
      .vehicle_no      (vehicle_no),
      .exit_req        (exit_req),
      .exit_vehicle_no (exit_vehicle_no),
      .slot_valid      (slot_valid),
      .slot_id         (slot_id),
      .park_reject     (park_reject),
      .exit_done       (exit_done),
      .exit_slot       (exit_slot),
      .exit_err        (exit_err),
      .occupancy       (occupancy),
      .full            (full),
      .busy            (busy),
      .overflow        (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] pulses();
      return {exit_err, exit_done, park_reject, slot_valid};
   endfunction

   // At most one result pulse per cycle.
   always @(negedge clk) begin
      if (!reset) check("onehot", 32'($countones(pulses()) <= 1), 32'd1);
   end

   // Drive one request cycle; returns at the next negedge (cycle T+1).
   task automatic pulse(input bit p, input logic [31:0] pv, input bit e, input logic [31:0] ev);
      @(negedge clk);
      car_parked      = p;
      vehicle_no      = pv;
      exit_req        = e;
      exit_vehicle_no = ev;
      @(negedge clk);
      car_parked = 1'b0;
      exit_req   = 1'b0;
   endtask

   // Wait for any result pulse; lat counts cycles after the request cycle.
   task automatic wait_any(output int lat, output logic [3:0] ev);
      lat = 1;
      ev  = pulses();
      while (ev == 4'b0 && lat < 40) begin
         @(negedge clk);
         lat++;
         ev = pulses();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic park_expect(input logic [31:0] v, input int exp_slot);
      int         lat;
      logic [3:0] ev;
      pulse(1'b1, v, 1'b0, 32'h0);
      wait_any(lat, ev);
      check($sformatf("park %0h ev", v), 32'(ev), 32'b0001);
      check($sformatf("park %0h lat", v), 32'(lat), 32'd2);
      check($sformatf("park %0h slot", v), 32'(slot_id), 32'(exp_slot));
   endtask

   task automatic exit_expect(input logic [31:0] v, input logic [3:0] exp_ev, input int exp_lat);
      int         lat;
      logic [3:0] ev;
      pulse(1'b0, 32'h0, 1'b1, v);
      wait_any(lat, ev);
      check($sformatf("exit %0h ev", v), 32'(ev), 32'(exp_ev));
      check($sformatf("exit %0h lat", v), 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      int         lat;
      logic [3:0] ev;
      logic [3:0] seen;
      logic [3:0] exp_tab [13];

      // Reset state
      @(negedge clk);
      check("rst pulses", 32'(pulses()), 32'h0);
      check("rst occupancy", 32'(occupancy), 32'd0);
      check("rst full", 32'(full), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst overflow", 32'(overflow), 32'd0);
      reset = 1'b0;

      // Test 1: first park lands in slot 0 at T+2
      park_expect(32'hA1, 0);
      check("t1 occupancy", 32'(occupancy), 32'd1);
      check("t1 busy", 32'(busy), 32'd0);

      // Test 2: fill the lot, then a 17th vehicle is rejected
      for (int i = 1; i < 16; i++) park_expect(32'hB0 + 32'(i), i);
      check("t2 full", 32'(full), 32'd1);
      check("t2 occupancy", 32'(occupancy), 32'd16);
      pulse(1'b1, 32'hFF, 1'b0, 32'h0);
      wait_any(lat, ev);
      check("t2 reject ev", 32'(ev), 32'b0010);
      check("t2 reject lat", 32'(lat), 32'd2);
      check("t2 occ after reject", 32'(occupancy), 32'd16);
      check("t2 full after reject", 32'(full), 32'd1);

      // Test 3: exit from slot 5 and reuse of slot 5
      do_reset();
      check("t3 occ after reset", 32'(occupancy), 32'd0);
      for (int i = 0; i < 6; i++) park_expect(32'h100 + 32'(i), i);
      exit_expect(32'h105, 4'b0100, 7);
      check("t3 exit_slot", 32'(exit_slot), 32'd5);
      check("t3 occupancy", 32'(occupancy), 32'd5);
      park_expect(32'h200, 5);
      check("t3 occ after reuse", 32'(occupancy), 32'd6);
      exit_expect(32'h100, 4'b0100, 2);
      check("t3 exit_slot 0", 32'(exit_slot), 32'd0);
      check("t3 occ after exit 0", 32'(occupancy), 32'd5);

      // Test 4: unknown and already-departed vehicles
      exit_expect(32'hDEAD, 4'b1000, 17);
      check("t4 occupancy", 32'(occupancy), 32'd5);
      exit_expect(32'h105, 4'b1000, 17);
      check("t4 occ stale", 32'(occupancy), 32'd5);

      // Test 5: park+exit collision, pending park, overflow
      do_reset();
      for (int i = 0; i < 4; i++) park_expect(32'h10 + 32'(i), i);
      for (int c = 0; c < 13; c++) exp_tab[c] = 4'b0000;
      exp_tab[2]  = 4'b0001;   // park 0x14 -> slot 4
      exp_tab[7]  = 4'b0100;   // exit 0x13 found in slot 3 (scan starts T+3)
      exp_tab[10] = 4'b0001;   // pending park 0x15 -> freed slot 3
      @(negedge clk);
      car_parked      = 1'b1;
      vehicle_no      = 32'h14;
      exit_req        = 1'b1;
      exit_vehicle_no = 32'h13;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         check($sformatf("t5 c%0d pulses", c), 32'(pulses()), 32'(exp_tab[c]));
         if (c == 2)  check("t5 slot_id 4", 32'(slot_id), 32'd4);
         if (c == 4)  check("t5 busy scan", 32'(busy), 32'd1);
         if (c == 5)  check("t5 ovf before", 32'(overflow), 32'd0);
         if (c == 6)  check("t5 ovf set", 32'(overflow), 32'd1);
         if (c == 7)  check("t5 exit_slot", 32'(exit_slot), 32'd3);
         if (c == 10) check("t5 slot_id 3", 32'(slot_id), 32'd3);
         car_parked = (c == 4) || (c == 5);
         vehicle_no = (c == 4) ? 32'h15 : 32'h16;
         exit_req   = 1'b0;
      end
      check("t5 occupancy", 32'(occupancy), 32'd5);
      check("t5 ovf sticky", 32'(overflow), 32'd1);
      exit_expect(32'h15, 4'b0100, 5);
      check("t5 exit_slot 0x15", 32'(exit_slot), 32'd3);
      exit_expect(32'h16, 4'b1000, 17);

      // Test 6: reset in the middle of a scan
      do_reset();
      check("t6 ovf cleared", 32'(overflow), 32'd0);
      park_expect(32'h50, 0);
      pulse(1'b0, 32'h0, 1'b1, 32'h99);
      repeat (3) @(negedge clk);
      check("t6 busy mid-scan", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("t6 occ in reset", 32'(occupancy), 32'd0);
      reset = 1'b0;
      seen = 4'b0;
      repeat (20) begin
         @(negedge clk);
         seen |= pulses();
      end
      check("t6 no pulses", 32'(seen), 32'h0);
      check("t6 occupancy", 32'(occupancy), 32'd0);
      check("t6 busy", 32'(busy), 32'd0);
      exit_expect(32'h50, 4'b1000, 17);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
